uart_cmd_assembler: RTL and testbench
=====================================

// Module: uart_cmd_assembler
// PURPOSE
//  DUT-side command front end of the Knights Tour robot. Consumes bytes from the UART receiver,
//  assembles each MSB-first byte pair into a 16-bit command, and presents it with a cmd_rdy flag.
//  Returns 8-bit responses (e.g. POS_ACK 8'hA5) to the remote through the UART transmitter.
//  Sits between UART rx/tx and the command processor; it is the far end of the host's send_cmd/resp link.
// PARAMETERS
//  BYTE_TIMEOUT  50000  max clocks allowed between high-byte capture and low-byte arrival
//  TMR_W         16     width of the inter-byte timer; must satisfy 2**TMR_W > BYTE_TIMEOUT
// PORTS
//  clk          in   1   system clock, single clock domain
//  RST_n        in   1   asynchronous active-low reset
//  rx_rdy       in   1   UART receiver holds a valid byte
//  rx_data      in   8   received byte
//  clr_rx_rdy   out  1   1-clk pulse acknowledging/consuming rx_data
//  cmd          out  16  assembled command {high,low}
//  cmd_rdy      out  1   cmd valid; level, held until cleared
//  clr_cmd_rdy  in   1   consumer has taken cmd
//  resp         in   8   response byte to send
//  snd_resp     in   1   1-clk request to transmit resp
//  tx_data      out  8   byte to UART transmitter
//  trmt         out  1   1-clk pulse starting a UART transmission
//  tx_done      in   1   transmitter finished current byte
//  resp_sent    out  1   1-clk pulse: response byte fully transmitted
//  byte_err     out  1   1-clk pulse: inter-byte timeout, partial command dropped
// BEHAVIOUR
//  Reset (async, RST_n low): all outputs 0, cmd=16'h0000, FSMs in idle, timer=0, pending=0.
//  Rx FSM states: WAIT_HI, WAIT_LO.
//   WAIT_HI & rx_rdy: latch rx_data->cmd[15:8], pulse clr_rx_rdy, clear cmd_rdy, clear timer, ->WAIT_LO.
//   WAIT_LO & rx_rdy: latch rx_data->cmd[7:0], pulse clr_rx_rdy, set cmd_rdy next clk, ->WAIT_HI.
//   WAIT_LO & timer==BYTE_TIMEOUT-1 & !rx_rdy: pulse byte_err, ->WAIT_HI; cmd_rdy stays 0.
//   rx_rdy and timeout on the same clk: the byte wins, no byte_err.
//  Each byte accepted exactly once: clr_rx_rdy asserted one clk; rx_rdy is ignored the following clk.
//  Latency: cmd_rdy rises 1 clk after the low-byte rx_rdy is sampled.
//  cmd_rdy clears on clr_cmd_rdy or on the next high-byte capture; set-on-low-byte beats clr_cmd_rdy
//   in the same clk. cmd[15:8] may change while cmd_rdy=0 only; cmd is stable while cmd_rdy=1.
//  Tx FSM states: TX_IDLE, TX_BUSY.
//   TX_IDLE & (snd_resp | pending): tx_data<=resp (or pending byte), pulse trmt, ->TX_BUSY.
//   TX_BUSY & snd_resp: store resp in 1-deep pending buffer; a later request overwrites it (last wins).
//   TX_BUSY & tx_done: pulse resp_sent; ->TX_IDLE, or issue pending byte the next clk.
//   tx_data is held constant from trmt through tx_done.
//  Rx and Tx paths are fully independent; simultaneous events on both are serviced in the same clk.
//  Reset mid-byte or mid-transmit: partial high byte and pending response are discarded.
// STRUCTURE
//  Shared package knights_pkg: POS_ACK=8'hA5, CAL_GYRO=16'h2000, typedefs rx_state_t, tx_state_t.
//  One sub-module: inter_byte_timer (TMR_W counter with clear/enable, terminal flag at BYTE_TIMEOUT-1).
// TESTING
//  Send 8'h20 then 8'h00 -> cmd=16'h2000, cmd_rdy=1 one clk after 2nd rx_rdy; clr_rx_rdy pulsed twice.
//  Hold cmd_rdy, assert clr_cmd_rdy -> cmd_rdy=0 next clk; cmd still 16'h2000.
//  Send 8'h41, wait BYTE_TIMEOUT clks -> byte_err pulse; then 8'h12,8'h34 -> cmd=16'h1234, not 16'h4112.
//  snd_resp resp=8'hA5 -> trmt pulse, tx_data=8'hA5; tx_done -> resp_sent pulse, Tx idle.
//  snd_resp 8'hA5 then 8'h5A while busy -> second trmt with 8'h5A immediately after first tx_done.
//  Assert RST_n low while in WAIT_LO and TX_BUSY -> all outputs 0; next pair starts cleanly at WAIT_HI.

Source files
------------

// File: rtl/uart_cmd_assembler_pkg.sv
// Shared constants and FSM state types for the robot command front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_cmd_assembler_pkg;

  // Well-known command/response codes exchanged with the host
  localparam logic [7:0]  POS_ACK  = 8'hA5;
  localparam logic [15:0] CAL_GYRO = 16'h2000;

  // Receive side: waiting for the high byte, then for the low byte
  typedef enum logic {
    WAIT_HI = 1'b0,
    WAIT_LO = 1'b1
  } rx_state_t;

  // Transmit side: idle, or one byte in flight in the UART transmitter
  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_BUSY = 1'b1
  } tx_state_t;

endpackage

// File: rtl/uart_cmd_assembler_if.sv
// Bundle of UART-side and command-processor-side signals of the assembler.
// Latency: n/a (wiring only).
// Backpressure: rx via clr_rx_rdy acknowledge, cmd via clr_cmd_rdy, tx via tx_done.
// Ports (slave = assembler side):
//   in : rx_rdy, rx_data, clr_cmd_rdy, resp, snd_resp, tx_done
//   out: clr_rx_rdy, cmd, cmd_rdy, tx_data, trmt, resp_sent, byte_err
interface uart_cmd_assembler_if;
  logic        rx_rdy;
  logic [7:0]  rx_data;
  logic        clr_rx_rdy;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic [7:0]  resp;
  logic        snd_resp;
  logic [7:0]  tx_data;
  logic        trmt;
  logic        tx_done;
  logic        resp_sent;
  logic        byte_err;

  modport slave (
    input  rx_rdy, rx_data, clr_cmd_rdy, resp, snd_resp, tx_done,
    output clr_rx_rdy, cmd, cmd_rdy, tx_data, trmt, resp_sent, byte_err
  );

  modport master (
    output rx_rdy, rx_data, clr_cmd_rdy, resp, snd_resp, tx_done,
    input  clr_rx_rdy, cmd, cmd_rdy, tx_data, trmt, resp_sent, byte_err
  );
endinterface

// File: rtl/uart_cmd_assembler_inter_byte_timer.sv
// Counts clocks spent waiting for the low byte; flags the last allowed clock.
// Latency: o_term is combinational from the count register.
// Backpressure: none; the counter parks at the terminal value until cleared.
// Ports: clk, RST_n, i_clr (sync clear, wins), i_en (count), o_term (count == BYTE_TIMEOUT-1).
module uart_cmd_assembler_inter_byte_timer #(
  parameter int unsigned BYTE_TIMEOUT = 50000,
  parameter int unsigned TMR_W        = 16
) (
  input  logic clk,
  input  logic RST_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_term
);

  localparam logic [TMR_W-1:0] TERM = TMR_W'(BYTE_TIMEOUT - 1);

  logic [TMR_W-1:0] r_cnt;
  logic             w_term;

  assign w_term = (r_cnt == TERM);
  assign o_term = w_term;

  // Parking at TERM keeps the counter from wrapping back into the valid window
  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !w_term) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_cmd_assembler.sv
// Assembles MSB-first UART byte pairs into 16-bit commands; sends 8-bit responses back.
// Latency: cmd_rdy/clr_rx_rdy 1 clk after rx_rdy sampled; trmt 1 clk after snd_resp (idle).
// Backpressure: rx bytes acked by a clr_rx_rdy pulse; tx holds one pending response while busy (last wins).
// Ports: clk, RST_n, bus (slave modport of uart_cmd_assembler_if).
module uart_cmd_assembler
  import uart_cmd_assembler_pkg::*;
#(
  parameter int unsigned BYTE_TIMEOUT = 50000,
  parameter int unsigned TMR_W        = 16
) (
  input  logic                 clk,
  input  logic                 RST_n,
  uart_cmd_assembler_if.slave  bus
);

  // ---------------------------------------------------------------- Rx path
  rx_state_t   r_rx_state, w_rx_nxt;
  logic [15:0] r_cmd;
  logic        r_cmd_rdy;
  logic        r_clr_rx_rdy;
  logic        r_byte_err;

  logic w_rx_take;
  logic w_cap_hi, w_cap_lo, w_tmo;
  logic w_tmr_clr, w_tmr_en, w_tmr_term;

  // The receiver still shows the byte we just acked for one clock; skip it
  assign w_rx_take = bus.rx_rdy & ~r_clr_rx_rdy;

  uart_cmd_assembler_inter_byte_timer #(
    .BYTE_TIMEOUT (BYTE_TIMEOUT),
    .TMR_W        (TMR_W)
  ) u_tmr (
    .clk    (clk),
    .RST_n  (RST_n),
    .i_clr  (w_tmr_clr),
    .i_en   (w_tmr_en),
    .o_term (w_tmr_term)
  );

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) r_rx_state <= WAIT_HI;
    else        r_rx_state <= w_rx_nxt;
  end

  always_comb begin
    w_rx_nxt = r_rx_state;
    unique case (r_rx_state)
      WAIT_HI: if (w_rx_take)               w_rx_nxt = WAIT_LO;
      WAIT_LO: if (w_rx_take || w_tmr_term) w_rx_nxt = WAIT_HI;
      default:                              w_rx_nxt = WAIT_HI;
    endcase
  end

  always_comb begin
    w_cap_hi  = 1'b0;
    w_cap_lo  = 1'b0;
    w_tmo     = 1'b0;
    w_tmr_clr = 1'b1;
    w_tmr_en  = 1'b0;
    unique case (r_rx_state)
      WAIT_HI: begin
        w_cap_hi = w_rx_take;
      end
      WAIT_LO: begin
        w_tmr_clr = 1'b0;
        w_tmr_en  = 1'b1;
        w_cap_lo  = w_rx_take;
        // A byte arriving on the last allowed clock still completes the pair
        w_tmo     = w_tmr_term & ~w_rx_take;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      r_cmd        <= '0;
      r_cmd_rdy    <= 1'b0;
      r_clr_rx_rdy <= 1'b0;
      r_byte_err   <= 1'b0;
    end else begin
      r_clr_rx_rdy <= w_cap_hi | w_cap_lo;
      r_byte_err   <= w_tmo;
      if (w_cap_hi) begin
        r_cmd[15:8] <= bus.rx_data;
        r_cmd_rdy   <= 1'b0;
      end else if (w_cap_lo) begin
        // Completing a command beats a simultaneous consumer clear
        r_cmd[7:0] <= bus.rx_data;
        r_cmd_rdy  <= 1'b1;
      end else if (bus.clr_cmd_rdy) begin
        r_cmd_rdy <= 1'b0;
      end
    end
  end

  assign bus.cmd        = r_cmd;
  assign bus.cmd_rdy    = r_cmd_rdy;
  assign bus.clr_rx_rdy = r_clr_rx_rdy;
  assign bus.byte_err   = r_byte_err;

  // ---------------------------------------------------------------- Tx path
  tx_state_t  r_tx_state, w_tx_nxt;
  logic [7:0] r_tx_data;
  logic       r_trmt;
  logic       r_resp_sent;
  logic       r_pend_vld;
  logic [7:0] r_pend_dat;

  logic       w_issue, w_done, w_pend_wr;
  logic [7:0] w_issue_dat;

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) r_tx_state <= TX_IDLE;
    else        r_tx_state <= w_tx_nxt;
  end

  always_comb begin
    w_tx_nxt = r_tx_state;
    unique case (r_tx_state)
      TX_IDLE: if (bus.snd_resp || r_pend_vld) w_tx_nxt = TX_BUSY;
      TX_BUSY: if (bus.tx_done)                w_tx_nxt = TX_IDLE;
      default:                                 w_tx_nxt = TX_IDLE;
    endcase
  end

  always_comb begin
    w_issue     = 1'b0;
    w_done      = 1'b0;
    w_pend_wr   = 1'b0;
    w_issue_dat = r_pend_vld ? r_pend_dat : bus.resp;
    unique case (r_tx_state)
      TX_IDLE: begin
        w_issue   = bus.snd_resp | r_pend_vld;
        // Older pending byte goes first; a fresh request queues behind it
        w_pend_wr = bus.snd_resp & r_pend_vld;
      end
      TX_BUSY: begin
        w_done    = bus.tx_done;
        w_pend_wr = bus.snd_resp;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      r_tx_data   <= '0;
      r_trmt      <= 1'b0;
      r_resp_sent <= 1'b0;
      r_pend_vld  <= 1'b0;
      r_pend_dat  <= '0;
    end else begin
      r_trmt      <= w_issue;
      r_resp_sent <= w_done;
      if (w_issue) r_tx_data <= w_issue_dat;
      if (w_pend_wr) begin
        r_pend_vld <= 1'b1;
        r_pend_dat <= bus.resp;
      end else if (w_issue) begin
        r_pend_vld <= 1'b0;
      end
    end
  end

  assign bus.tx_data   = r_tx_data;
  assign bus.trmt      = r_trmt;
  assign bus.resp_sent = r_resp_sent;

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// Testbench for uart_cmd_assembler: directed scenarios then randomized rx/tx traffic.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_cmd_assembler;
  import uart_cmd_assembler_pkg::*;

  localparam int T = 24;

  logic clk   = 1'b0;
  logic RST_n = 1'b0;
  always #5 clk = ~clk;

  uart_cmd_assembler_if u_if ();

  uart_cmd_assembler #(
    .BYTE_TIMEOUT (T),
    .TMR_W        (8)
  ) dut (
    .clk   (clk),
    .RST_n (RST_n),
    .bus   (u_if)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int n_clr  = 0;
  int n_trmt = 0;
  int n_sent = 0;
  int n_err  = 0;
  logic [7:0] tx_seen[$];

  // Pulse counters, sampled on the inactive edge
  always @(negedge clk) begin
    if (RST_n) begin
      if (u_if.clr_rx_rdy) n_clr++;
      if (u_if.resp_sent)  n_sent++;
      if (u_if.byte_err)   n_err++;
      if (u_if.trmt) begin
        n_trmt++;
        tx_seen.push_back(u_if.tx_data);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Emulates the UART receiver: hold the byte until acknowledged (bounded)
  task automatic send_byte(input logic [7:0] b);
    int k;
    k = 0;
    u_if.rx_data = b;
    u_if.rx_rdy  = 1'b1;
    step();
    while (!u_if.clr_rx_rdy && k < 8) begin
      step();
      k++;
    end
    chk("rx_ack", {31'd0, u_if.clr_rx_rdy}, 32'd1);
    u_if.rx_rdy = 1'b0;
  endtask

  initial begin
    int e0, e1, m, gap;
    logic [7:0] hi, lo, lo2, b0, last;
    logic [15:0] exp_cmd;
    logic [7:0] exp_q[$];

    u_if.rx_rdy = 0; u_if.rx_data = 0; u_if.clr_cmd_rdy = 0;
    u_if.resp = 0; u_if.snd_resp = 0; u_if.tx_done = 0;

    // Reset state
    repeat (3) step();
    chk("reset_outs", {3'd0, u_if.cmd, u_if.cmd_rdy, u_if.clr_rx_rdy, u_if.tx_data,
                       u_if.trmt, u_if.resp_sent, u_if.byte_err}, 32'd0);
    RST_n = 1'b1;
    step();

    // CAL_GYRO pair
    e0 = n_clr;
    send_byte(8'h20);
    chk("hi_no_rdy", {31'd0, u_if.cmd_rdy}, 32'd0);
    send_byte(8'h00);
    chk("lo_rdy_1clk", {31'd0, u_if.cmd_rdy}, 32'd1);
    chk("cmd_cal", {16'd0, u_if.cmd}, {16'd0, CAL_GYRO});
    step();
    chk("clr_twice", n_clr - e0, 32'd2);
    chk("rdy_held", {31'd0, u_if.cmd_rdy}, 32'd1);

    // Consumer clears cmd_rdy; cmd stays
    u_if.clr_cmd_rdy = 1'b1;
    step();
    u_if.clr_cmd_rdy = 1'b0;
    chk("rdy_cleared", {31'd0, u_if.cmd_rdy}, 32'd0);
    chk("cmd_kept", {16'd0, u_if.cmd}, 32'h2000);

    // Timeout after a lone high byte
    e0 = n_err;
    send_byte(8'h41);
    repeat (T - 1) step();
    chk("no_err_early", {31'd0, u_if.byte_err}, 32'd0);
    step();
    chk("byte_err_pulse", {31'd0, u_if.byte_err}, 32'd1);
    step();
    chk("byte_err_once", n_err - e0, 32'd1);
    chk("tmo_no_rdy", {31'd0, u_if.cmd_rdy}, 32'd0);
    send_byte(8'h12);
    send_byte(8'h34);
    chk("cmd_after_tmo", {16'd0, u_if.cmd}, 32'h1234);

    // Low byte on the last allowed clock is accepted
    e0 = n_err;
    send_byte(8'hAA);
    repeat (T - 1) step();
    send_byte(8'h55);
    chk("edge_accept", {16'd0, u_if.cmd}, 32'hAA55);
    step();
    chk("edge_no_err", n_err - e0, 32'd0);

    // One clock later is too late: the late byte starts a new command
    send_byte(8'h66);
    repeat (T) step();
    send_byte(8'h77);
    send_byte(8'h88);
    chk("late_cmd", {16'd0, u_if.cmd}, 32'h7788);
    step();
    chk("late_err", n_err - e0, 32'd1);

    // Completing a command beats a simultaneous clr_cmd_rdy
    send_byte(8'h9C);
    u_if.clr_cmd_rdy = 1'b1;
    send_byte(8'h3E);
    u_if.clr_cmd_rdy = 1'b0;
    chk("set_beats_clr", {31'd0, u_if.cmd_rdy}, 32'd1);

    // Single response
    e0 = n_trmt; e1 = n_sent;
    u_if.resp = POS_ACK; u_if.snd_resp = 1'b1;
    step();
    u_if.snd_resp = 1'b0;
    chk("trmt_pulse", {23'd0, u_if.trmt, u_if.tx_data}, {23'd0, 1'b1, POS_ACK});
    repeat (3) step();
    chk("tx_hold", {23'd0, u_if.trmt, u_if.tx_data}, {23'd0, 1'b0, POS_ACK});
    u_if.tx_done = 1'b1;
    step();
    u_if.tx_done = 1'b0;
    chk("resp_sent", {31'd0, u_if.resp_sent}, 32'd1);
    repeat (3) step();
    chk("tx_idle_cnt", {n_trmt - e0, n_sent - e1}, {32'd1, 32'd1});

    // Pending response, last request wins
    e0 = n_trmt;
    u_if.resp = 8'hA5; u_if.snd_resp = 1'b1; step();
    u_if.resp = 8'h11; step();
    u_if.resp = 8'h5A; step();
    u_if.snd_resp = 1'b0;
    chk("busy_hold", {24'd0, u_if.tx_data}, 32'hA5);
    u_if.tx_done = 1'b1; step(); u_if.tx_done = 1'b0;
    chk("pend_not_yet", {31'd0, u_if.trmt}, 32'd0);
    step();
    chk("pend_issue", {23'd0, u_if.trmt, u_if.tx_data}, {23'd0, 1'b1, 8'h5A});
    u_if.tx_done = 1'b1; step(); u_if.tx_done = 1'b0;
    repeat (3) step();
    chk("pend_count", n_trmt - e0, 32'd2);

    // Rx and Tx events on the same clock
    u_if.rx_data = 8'h5D; u_if.rx_rdy = 1'b1;
    u_if.resp = 8'hC4; u_if.snd_resp = 1'b1;
    step();
    u_if.rx_rdy = 1'b0; u_if.snd_resp = 1'b0;
    chk("simul", {30'd0, u_if.clr_rx_rdy, u_if.trmt}, 32'd3);
    send_byte(8'hE1);
    chk("simul_cmd", {16'd0, u_if.cmd}, 32'h5DE1);
    u_if.tx_done = 1'b1; step(); u_if.tx_done = 1'b0;
    step();

    // Reset while in WAIT_LO with a transmission and a pending byte
    send_byte(8'hC3);
    u_if.resp = 8'hA5; u_if.snd_resp = 1'b1; step();
    u_if.resp = 8'h5A; step();
    u_if.snd_resp = 1'b0;
    RST_n = 1'b0;
    #1;
    chk("mid_reset_outs", {3'd0, u_if.cmd, u_if.cmd_rdy, u_if.clr_rx_rdy, u_if.tx_data,
                           u_if.trmt, u_if.resp_sent, u_if.byte_err}, 32'd0);
    step();
    RST_n = 1'b1;
    e0 = n_trmt;
    repeat (5) step();
    chk("pend_dropped", n_trmt - e0, 32'd0);
    send_byte(8'h20);
    send_byte(8'h00);
    chk("clean_pair", {16'd0, u_if.cmd}, 32'h2000);

    // Random byte pairs with random inter-byte gaps
    for (int i = 0; i < 30; i++) begin
      hi  = 8'($urandom);
      lo  = 8'($urandom);
      lo2 = 8'($urandom);
      gap = $urandom_range(0, T + 2);
      e0  = n_err;
      send_byte(hi);
      repeat (gap) step();
      send_byte(lo);
      if (gap < T) begin
        exp_cmd = {hi, lo};
        e1 = 0;
      end else begin
        send_byte(lo2);
        exp_cmd = {lo, lo2};
        e1 = 1;
      end
      chk("rnd_cmd", {16'd0, u_if.cmd}, {16'd0, exp_cmd});
      chk("rnd_rdy", {31'd0, u_if.cmd_rdy}, 32'd1);
      step();
      chk("rnd_err", n_err - e0, e1);
    end

    // Random response bursts
    tx_seen.delete();
    e1 = n_sent;
    for (int r = 0; r < 12; r++) begin
      b0 = 8'($urandom);
      u_if.resp = b0; u_if.snd_resp = 1'b1; step(); u_if.snd_resp = 1'b0;
      exp_q.push_back(b0);
      m = $urandom_range(0, 3);
      last = 8'h00;
      for (int j = 0; j < m; j++) begin
        last = 8'($urandom);
        u_if.resp = last; u_if.snd_resp = 1'b1; step(); u_if.snd_resp = 1'b0;
      end
      repeat ($urandom_range(0, 3)) step();
      chk("rnd_tx_hold", {24'd0, u_if.tx_data}, {24'd0, b0});
      u_if.tx_done = 1'b1; step(); u_if.tx_done = 1'b0;
      step();
      if (m > 0) begin
        exp_q.push_back(last);
        u_if.tx_done = 1'b1; step(); u_if.tx_done = 1'b0;
        step();
      end
    end
    step();
    chk("rnd_tx_count", tx_seen.size(), exp_q.size());
    chk("rnd_sent_count", n_sent - e1, exp_q.size());
    for (int k = 0; k < exp_q.size() && k < tx_seen.size(); k++)
      chk("rnd_tx_byte", {24'd0, tx_seen[k]}, {24'd0, exp_q[k]});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
